rs_slot_ctrl: RTL and testbench

Occupancy and slot-selection controller for the reservation station. Tracks which RS entries are busy. Produces a one-hot allocation vector for dispatch and a registered one-hot issue grant for the functional units. Both one-hot vectors go to onehot_to_binary_RS instances for entry indexing.

---
 rtl/rs_slot_ctrl.sv | 101 ++++++++++
 tb/tb_rs_slot_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rs_slot_ctrl.sv
// Reservation-station occupancy tracker: picks the lowest free entry for dispatch
// and grants one busy, ready entry per cycle to the FUs using a round-robin pointer.
module rs_slot_ctrl #(
   parameter int unsigned N = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 squash,
   input  logic                 dispatch_req,
   output logic [N-1:0]         alloc_oh,
   output logic                 alloc_valid,
   input  logic [N-1:0]         ready,
   input  logic                 issue_stall,
   output logic [N-1:0]         issue_oh,
   output logic                 issue_valid,
   output logic [N-1:0]         busy,
   output logic [$clog2(N):0]   free_count,
   output logic                 full
);

   localparam int unsigned IW = $clog2(N);
   localparam int unsigned CW = IW + 1;

   logic [IW-1:0] rr_ptr;
   logic [N-1:0]  free_vec;
   logic [N-1:0]  cand;
   logic [N-1:0]  alloc_set;
   logic [N-1:0]  pick_oh;
   logic [IW-1:0] pick_hi;
   logic [IW-1:0] pick_lo;
   logic [IW-1:0] pick_idx;
   logic [IW-1:0] rr_next;
   logic          found_hi;
   logic          found_lo;
   logic          do_issue;

   // Lowest-index free entry; zero when every entry is busy.
   always_comb begin
      free_vec    = ~busy;
      alloc_oh    = free_vec & (~free_vec + N'(1));
      alloc_valid = |free_vec;
      full        = &busy;
      alloc_set   = (dispatch_req && alloc_valid) ? alloc_oh : '0;
   end

   always_comb begin
      free_count = CW'(N);
      for (int unsigned i = 0; i < N; i++) begin
         free_count = free_count - CW'(busy[i]);
      end
   end

   // Round-robin: first candidate at or above rr_ptr, otherwise wrap to the lowest one.
   always_comb begin
      cand     = busy & ready;
      pick_hi  = '0;
      pick_lo  = '0;
      found_hi = 1'b0;
      found_lo = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (cand[i] && !found_lo) begin
            pick_lo  = IW'(i);
            found_lo = 1'b1;
         end
         if (cand[i] && !found_hi && (IW'(i) >= rr_ptr)) begin
            pick_hi  = IW'(i);
            found_hi = 1'b1;
         end
      end
      pick_idx = found_hi ? pick_hi : pick_lo;
      do_issue = found_lo && !issue_stall;
      pick_oh  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         pick_oh[i] = do_issue && (IW'(i) == pick_idx);
      end
      rr_next  = (int'(pick_idx) == int'(N) - 1) ? '0 : pick_idx + IW'(1);
   end

   // Squash dominates both dispatch and issue in the same cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy        <= '0;
         issue_oh    <= '0;
         issue_valid <= 1'b0;
         rr_ptr      <= '0;
      end else if (squash) begin
         busy        <= '0;
         issue_oh    <= '0;
         issue_valid <= 1'b0;
         rr_ptr      <= '0;
      end else begin
         busy        <= (busy | alloc_set) & ~pick_oh;
         issue_oh    <= pick_oh;
         issue_valid <= do_issue;
         if (do_issue) begin
            rr_ptr <= rr_next;
         end
      end
   end

endmodule

// File: tb/tb_rs_slot_ctrl.sv
// Directed bench for rs_slot_ctrl: per-edge expectations are queued when a cycle
// is driven and popped after the edge to compare issue grant and occupancy.
module tb_rs_slot_ctrl;

   localparam int unsigned N = 16;

   logic          clock;
   logic          reset;
   logic          squash;
   logic          dispatch_req;
   logic [N-1:0]  alloc_oh;
   logic          alloc_valid;
   logic [N-1:0]  ready;
   logic          issue_stall;
   logic [N-1:0]  issue_oh;
   logic          issue_valid;
   logic [N-1:0]  busy;
   logic [4:0]    free_count;
   logic          full;

   typedef struct {
      string        tag;
      logic [15:0]  issue;
      logic [15:0]  busy;
   } exp_t;

   exp_t sb[$];
   int   vectors;
   int   miscompares;

   rs_slot_ctrl #(.N(N)) dut (
      .clock        (clock),
      .reset        (reset),
      .squash       (squash),
      .dispatch_req (dispatch_req),
      .alloc_oh     (alloc_oh),
      .alloc_valid  (alloc_valid),
      .ready        (ready),
      .issue_stall  (issue_stall),
      .issue_oh     (issue_oh),
      .issue_valid  (issue_valid),
      .busy         (busy),
      .free_count   (free_count),
      .full         (full)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, queue its expected outcome, then check after the edge.
   task automatic step(input logic disp, input logic [15:0] rdy, input logic stall,
                       input logic sq, input logic [15:0] exp_issue,
                       input logic [15:0] exp_busy, input string tag);
      exp_t e;
      dispatch_req = disp;
      ready        = rdy;
      issue_stall  = stall;
      squash       = sq;
      sb.push_back('{tag, exp_issue, exp_busy});
      @(posedge clock);
      #1;
      e = sb.pop_front();
      chk({e.tag, "_issue_oh"}, 32'(issue_oh), 32'(e.issue));
      chk({e.tag, "_issue_valid"}, 32'(issue_valid), 32'(|e.issue));
      chk({e.tag, "_busy"}, 32'(busy), 32'(e.busy));
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic check_empty(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_alloc_oh"}, 32'(alloc_oh), 32'h1);
      chk({tag, "_alloc_valid"}, 32'(alloc_valid), 32'h1);
      chk({tag, "_free_count"}, 32'(free_count), 32'd16);
      chk({tag, "_issue_valid"}, 32'(issue_valid), 32'h0);
      chk({tag, "_full"}, 32'(full), 32'h0);
   endtask

   initial begin
      logic [31:0] bexp;
      vectors      = 0;
      miscompares  = 0;
      reset        = 1'b1;
      squash       = 1'b0;
      dispatch_req = 1'b0;
      ready        = '0;
      issue_stall  = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      check_empty("reset");

      // Fill all entries in order.
      for (int i = 0; i < 16; i++) begin
         chk("fill_alloc_oh", 32'(alloc_oh), 32'h1 << i);
         bexp = (32'h1 << (i + 1)) - 32'h1;
         step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'(bexp), "fill");
      end
      chk("full_flag", 32'(full), 32'h1);
      chk("full_alloc_valid", 32'(alloc_valid), 32'h0);
      chk("full_alloc_oh", 32'(alloc_oh), 32'h0);
      chk("full_free_count", 32'(free_count), 32'h0);
      step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hFFFF, "fill_17th");

      // Round-robin wrap from entry 0 to entry 15.
      step(1'b0, 16'h8001, 1'b0, 1'b0, 16'h0001, 16'hFFFE, "rr_e1");
      step(1'b0, 16'h8001, 1'b0, 1'b0, 16'h8000, 16'h7FFE, "rr_e2");
      step(1'b0, 16'h8001, 1'b0, 1'b0, 16'h0000, 16'h7FFE, "rr_e3");

      // Refill, then issue and dispatch on the same edge while full.
      step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h7FFF, "refill0");
      step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hFFFF, "refill15");
      step(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0020, 16'hFFDF, "full_iss");
      chk("full_iss_alloc_oh", 32'(alloc_oh), 32'h0020);
      chk("full_iss_free_count", 32'(free_count), 32'd1);
      step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hFFFF, "full_iss_refill");

      // Async reset in the middle of a cycle with busy=0x00FF.
      pulse_reset();
      #1;
      for (int i = 0; i < 8; i++) begin
         bexp = (32'h1 << (i + 1)) - 32'h1;
         step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'(bexp), "pre_rst");
      end
      reset = 1'b1;
      #1;
      check_empty("mid_reset");
      reset = 1'b0;

      // Stall holds off issue; release grants entry 0.
      for (int i = 0; i < 4; i++) begin
         bexp = (32'h1 << (i + 1)) - 32'h1;
         step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'(bexp), "stall_fill");
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 16'h000F, 1'b1, 1'b0, 16'h0000, 16'h000F, "stall");
      end
      step(1'b0, 16'h000F, 1'b0, 1'b0, 16'h0001, 16'h000E, "stall_rel");
      step(1'b0, 16'h000F, 1'b0, 1'b0, 16'h0002, 16'h000C, "stall_rr");

      // Build busy=0x0F0F with rr_ptr=8, then squash.
      @(negedge clock);
      pulse_reset();
      for (int i = 0; i < 12; i++) begin
         bexp = (32'h1 << (i + 1)) - 32'h1;
         step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'(bexp), "sq_fill");
      end
      step(1'b0, 16'h00F0, 1'b0, 1'b0, 16'h0010, 16'h0FEF, "sq_iss4");
      step(1'b0, 16'h00F0, 1'b0, 1'b0, 16'h0020, 16'h0FCF, "sq_iss5");
      step(1'b0, 16'h00F0, 1'b0, 1'b0, 16'h0040, 16'h0F8F, "sq_iss6");
      step(1'b0, 16'h00F0, 1'b0, 1'b0, 16'h0080, 16'h0F0F, "sq_iss7");
      step(1'b1, 16'h0001, 1'b0, 1'b1, 16'h0000, 16'h0000, "squash");
      check_empty("post_squash");

      // rr_ptr must be back at 0: entry 0 wins over entry 9.
      for (int i = 0; i < 10; i++) begin
         bexp = (32'h1 << (i + 1)) - 32'h1;
         step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'(bexp), "rr0_fill");
      end
      step(1'b0, 16'h0201, 1'b0, 1'b0, 16'h0001, 16'h03FE, "rr0_pick");
      step(1'b0, 16'h0201, 1'b0, 1'b0, 16'h0200, 16'h01FE, "rr0_next");
      chk("final_free_count", 32'(free_count), 32'd8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
